udp_rx_pingpong: RTL and testbench

//  Parametrised UDP receive engine between the IP RX parser and user logic. Takes the UDP

---
 rtl/udp_rx_pingpong.sv | 224 ++++++++++++++++++++++
 tb/tb_udp_rx_pingpong.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pingpong.sv
// rtl/udp_rx_pingpong.sv - UDP receive engine with checksum verify, port filter and ping-pong payload buffers
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   udp_rx_start/valid/data       UDP byte stream from the IP parser (start pulse precedes byte 0)
//   upper_layer_data_length       IP payload length, stable for the whole packet
//   net_protocol, ip_rec_*_addr   pseudo-header fields
//   ip_checksum_error, ip_addr_check_error, mac_rec_error   abort the packet in flight
//   cfg_port_en, cfg_local_port   destination port filter
//   rd_addr, rd_data              payload read port into the read buffer (1-cycle latency)
//   rec_valid/length/src_port/dst_port, rec_release   read buffer handshake
//   err_cnt, drop_cnt             saturating statistics
module udp_rx_pingpong #(
  parameter int ADDR_W          = 11,
  parameter bit CHK_ZERO_BYPASS = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              udp_rx_start,
  input  logic              udp_rx_valid,
  input  logic [7:0]        udp_rx_data,
  input  logic [15:0]       upper_layer_data_length,
  input  logic [7:0]        net_protocol,
  input  logic [31:0]       ip_rec_source_addr,
  input  logic [31:0]       ip_rec_dest_addr,
  input  logic              ip_checksum_error,
  input  logic              ip_addr_check_error,
  input  logic              mac_rec_error,
  input  logic              cfg_port_en,
  input  logic [15:0]       cfg_local_port,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rec_valid,
  output logic [15:0]       rec_length,
  output logic [15:0]       rec_src_port,
  output logic [15:0]       rec_dst_port,
  input  logic              rec_release,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEAD   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PAD    = 3'd3;
  localparam logic [2:0] S_VER1   = 3'd4;
  localparam logic [2:0] S_VER2   = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  localparam logic [2:0] S_DROP   = 3'd7;
  localparam logic [16:0] MAX_PAYLOAD = 17'(2**ADDR_W);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, chk_q, chk_d;
  logic [7:0]  hi_q, hi_d;
  logic [31:0] acc_q, acc_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  full_q;
  logic [15:0] buf_len_q [2];
  logic [15:0] buf_src_q [2];
  logic [15:0] buf_dst_q [2];
  logic [CNT_W-1:0] err_cnt_q, drop_cnt_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  mem [0:2*(2**ADDR_W)-1];

  logic        err_inc, drop_inc, commit, wr_en, in_pkt, pkt_err;
  logic [31:0] fold;
  logic [16:0] pay_len;
  logic [ADDR_W-1:0] wr_idx;

  assign in_pkt  = (state_q != S_IDLE) && (state_q != S_DROP);
  assign pkt_err = ip_checksum_error | ip_addr_check_error | mac_rec_error;
  // end-around carry fold of the one's-complement accumulator
  assign fold    = {16'h0, acc_q[31:16]} + {16'h0, acc_q[15:0]};
  assign pay_len = {1'b0, len_q} - 17'd8;
  assign wr_idx  = cnt_q[ADDR_W-1:0] - ADDR_W'(8);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    chk_d    = chk_q;
    hi_d     = hi_q;
    acc_d    = acc_q;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    commit   = 1'b0;
    wr_en    = 1'b0;
    if (udp_rx_start) begin
      // a start always wins: abort anything in flight; with no free buffer the packet is dropped
      drop_inc = in_pkt || full_q[wr_ptr_q];
      cnt_d    = 16'd0;
      acc_d    = {16'h0, ip_rec_source_addr[31:16]} + {16'h0, ip_rec_source_addr[15:0]}
               + {16'h0, ip_rec_dest_addr[31:16]} + {16'h0, ip_rec_dest_addr[15:0]}
               + {24'h0, net_protocol} + {16'h0, upper_layer_data_length};
      state_d  = full_q[wr_ptr_q] ? S_DROP : S_HEAD;
    end else if (in_pkt && pkt_err) begin
      drop_inc = 1'b1;
      state_d  = S_DROP;
    end else begin
      case (state_q)
        S_HEAD, S_DATA: begin
          if (udp_rx_valid) begin
            cnt_d = cnt_q + 16'd1;
            // even-index bytes are held as the high half of the next 16-bit word
            if (cnt_q[0]) acc_d = acc_q + {16'h0, hi_q, udp_rx_data};
            else          hi_d  = udp_rx_data;
            if (state_q == S_HEAD) begin
              case (cnt_q[2:0])
                3'd0: src_d[15:8] = udp_rx_data;
                3'd1: src_d[7:0]  = udp_rx_data;
                3'd2: dst_d[15:8] = udp_rx_data;
                3'd3: dst_d[7:0]  = udp_rx_data;
                3'd4: len_d[15:8] = udp_rx_data;
                3'd5: len_d[7:0]  = udp_rx_data;
                3'd6: chk_d[15:8] = udp_rx_data;
                default: begin
                  chk_d[7:0] = udp_rx_data;
                  if (len_q < 16'd8 || len_q != upper_layer_data_length || pay_len > MAX_PAYLOAD) begin
                    err_inc = 1'b1;
                    state_d = S_DROP;
                  end else if (cfg_port_en && dst_q != cfg_local_port) begin
                    drop_inc = 1'b1;
                    state_d  = S_DROP;
                  end else if (len_q == 16'd8) begin
                    state_d = S_VER1;
                  end else begin
                    state_d = S_DATA;
                  end
                end
              endcase
            end else begin
              wr_en = 1'b1;
              if (cnt_q == len_q - 16'd1) state_d = len_q[0] ? S_PAD : S_VER1;
            end
          end
        end
        S_PAD: begin
          acc_d   = acc_q + {16'h0, hi_q, 8'h00};
          state_d = S_VER1;
        end
        S_VER1: begin
          acc_d   = fold;
          state_d = S_VER2;
        end
        S_VER2: begin
          acc_d = fold;
          if (fold[15:0] == 16'hFFFF || (CHK_ZERO_BYPASS && chk_q == 16'h0)) begin
            state_d = S_COMMIT;
          end else begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end
        end
        S_COMMIT: begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
        S_DROP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      hi_q       <= '0;
      acc_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_q     <= 2'b00;
      buf_len_q  <= '{16'h0, 16'h0};
      buf_src_q  <= '{16'h0, 16'h0};
      buf_dst_q  <= '{16'h0, 16'h0};
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      if (commit) begin
        full_q[wr_ptr_q]    <= 1'b1;
        buf_len_q[wr_ptr_q] <= len_q - 16'd8;
        buf_src_q[wr_ptr_q] <= src_q;
        buf_dst_q[wr_ptr_q] <= dst_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      // commit only targets a free buffer, so it never collides with the one being released
      if (rec_valid && rec_release) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
      if (err_inc && err_cnt_q != '1)   err_cnt_q  <= err_cnt_q + CNT_W'(1);
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      rd_data_q <= mem[{rd_ptr_q, rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_ptr_q, wr_idx}] <= udp_rx_data;
  end

  assign rd_data      = rd_data_q;
  assign rec_valid    = full_q[rd_ptr_q];
  assign rec_length   = buf_len_q[rd_ptr_q];
  assign rec_src_port = buf_src_q[rd_ptr_q];
  assign rec_dst_port = buf_dst_q[rd_ptr_q];
  assign err_cnt      = err_cnt_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_udp_rx_pingpong.sv
// tb/tb_udp_rx_pingpong.sv - directed self-checking bench for udp_rx_pingpong
module tb_udp_rx_pingpong;
  logic        clk = 1'b0;
  logic        rstn;
  logic        udp_rx_start, udp_rx_valid;
  logic [7:0]  udp_rx_data;
  logic [15:0] upper_layer_data_length;
  logic [7:0]  net_protocol;
  logic [31:0] ip_rec_source_addr, ip_rec_dest_addr;
  logic        ip_checksum_error, ip_addr_check_error, mac_rec_error;
  logic        cfg_port_en;
  logic [15:0] cfg_local_port;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rec_valid;
  logic [15:0] rec_length, rec_src_port, rec_dst_port;
  logic        rec_release;
  logic [15:0] err_cnt, drop_cnt;

  int total = 0;
  int bad = 0;
  logic [7:0] pkt [$];

  always #5 clk = ~clk;

  udp_rx_pingpong #(.ADDR_W(11), .CHK_ZERO_BYPASS(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .udp_rx_start(udp_rx_start), .udp_rx_valid(udp_rx_valid), .udp_rx_data(udp_rx_data),
    .upper_layer_data_length(upper_layer_data_length), .net_protocol(net_protocol),
    .ip_rec_source_addr(ip_rec_source_addr), .ip_rec_dest_addr(ip_rec_dest_addr),
    .ip_checksum_error(ip_checksum_error), .ip_addr_check_error(ip_addr_check_error),
    .mac_rec_error(mac_rec_error), .cfg_port_en(cfg_port_en), .cfg_local_port(cfg_local_port),
    .rd_addr(rd_addr), .rd_data(rd_data), .rec_valid(rec_valid), .rec_length(rec_length),
    .rec_src_port(rec_src_port), .rec_dst_port(rec_dst_port), .rec_release(rec_release),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] pay(input logic [7:0] seed, input int i);
    return seed + 8'(i * 7);
  endfunction

  // sender-side UDP packet with standard one's-complement checksum over pseudo header
  task automatic build(input logic [15:0] sp, input logic [15:0] dp, input int plen,
                       input logic [7:0] seed, input bit zero_chk);
    logic [31:0] s;
    logic [15:0] c;
    pkt.delete();
    upper_layer_data_length = 16'(plen + 8);
    pkt.push_back(sp[15:8]); pkt.push_back(sp[7:0]);
    pkt.push_back(dp[15:8]); pkt.push_back(dp[7:0]);
    pkt.push_back(upper_layer_data_length[15:8]); pkt.push_back(upper_layer_data_length[7:0]);
    pkt.push_back(8'h00); pkt.push_back(8'h00);
    for (int i = 0; i < plen; i++) pkt.push_back(pay(seed, i));
    s = 32'h0A00 + 32'h0002 + 32'h0A00 + 32'h0001 + 32'd17 + {16'h0, upper_layer_data_length};
    for (int i = 0; i < pkt.size(); i += 2) begin
      if (i + 1 < pkt.size()) s = s + {16'h0, pkt[i], pkt[i+1]};
      else                    s = s + {16'h0, pkt[i], 8'h00};
    end
    s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
    s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
    c = ~s[15:0];
    if (c == 16'h0) c = 16'hFFFF;
    if (!zero_chk) begin
      pkt[6] = c[15:8];
      pkt[7] = c[7:0];
    end
  endtask

  // start pulse, then n bytes with an idle gap before every fifth byte
  task automatic send(input int n);
    udp_rx_start = 1'b1;
    step();
    udp_rx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 3) begin
        udp_rx_valid = 1'b0;
        step();
      end
      udp_rx_valid = 1'b1;
      udp_rx_data  = pkt[i];
      step();
    end
    udp_rx_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && rec_valid !== 1'b1; i++) step();
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = 11'(addr);
    step();
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic release_buf();
    rec_release = 1'b1;
    step();
    rec_release = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    steps(2);
    rstn = 1'b1;
    step();
  endtask

  initial begin
    rstn = 1'b0; udp_rx_start = 1'b0; udp_rx_valid = 1'b0; udp_rx_data = 8'h00;
    upper_layer_data_length = 16'h0; net_protocol = 8'd17;
    ip_rec_source_addr = 32'h0A00_0002; ip_rec_dest_addr = 32'h0A00_0001;
    ip_checksum_error = 1'b0; ip_addr_check_error = 1'b0; mac_rec_error = 1'b0;
    cfg_port_en = 1'b0; cfg_local_port = 16'd5000; rd_addr = '0; rec_release = 1'b0;
    steps(3);
    check("rst_valid", {31'h0, rec_valid}, 32'h0);
    check("rst_len", {16'h0, rec_length}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    check("rst_err", {16'h0, err_cnt}, 32'h0);
    check("rst_drop", {16'h0, drop_cnt}, 32'h0);
    rstn = 1'b1;
    step();

    // 1: 18-byte payload, latency and content
    build(16'd1234, 16'd5000, 18, 8'h10, 1'b0);
    send(pkt.size());
    steps(2);
    check("t1_lat2", {31'h0, rec_valid}, 32'h0);
    step();
    check("t1_lat3", {31'h0, rec_valid}, 32'h1);
    check("t1_len", {16'h0, rec_length}, 32'd18);
    check("t1_src", {16'h0, rec_src_port}, 32'd1234);
    check("t1_dst", {16'h0, rec_dst_port}, 32'd5000);
    for (int k = 0; k < 18; k++) read_chk("t1_data", k, pay(8'h10, k));
    release_buf();
    check("t1_released", {31'h0, rec_valid}, 32'h0);

    // 2: odd payload via PAD, then a corrupted copy
    build(16'd1234, 16'd5000, 17, 8'h21, 1'b0);
    send(pkt.size());
    wait_valid(10);
    check("t2_valid", {31'h0, rec_valid}, 32'h1);
    check("t2_len", {16'h0, rec_length}, 32'd17);
    read_chk("t2_last", 16, pay(8'h21, 16));
    release_buf();
    build(16'd1234, 16'd5000, 17, 8'h21, 1'b0);
    pkt[10] = pkt[10] ^ 8'h01;
    send(pkt.size());
    steps(8);
    check("t2_bad_valid", {31'h0, rec_valid}, 32'h0);
    check("t2_err", {16'h0, err_cnt}, 32'd1);

    // 3: three packets, two buffers
    do_reset();
    build(16'd1, 16'd2, 4, 8'h30, 1'b0); send(pkt.size()); steps(5);
    build(16'd3, 16'd4, 6, 8'h40, 1'b0); send(pkt.size()); steps(5);
    build(16'd5, 16'd6, 8, 8'h50, 1'b0); send(pkt.size()); steps(5);
    check("t3_drop", {16'h0, drop_cnt}, 32'd1);
    check("t3_valid1", {31'h0, rec_valid}, 32'h1);
    check("t3_len1", {16'h0, rec_length}, 32'd4);
    read_chk("t3_d1", 3, 8'h45);
    release_buf();
    check("t3_valid2", {31'h0, rec_valid}, 32'h1);
    check("t3_len2", {16'h0, rec_length}, 32'd6);
    check("t3_src2", {16'h0, rec_src_port}, 32'd3);
    read_chk("t3_d2", 5, 8'h63);
    release_buf();
    check("t3_empty", {31'h0, rec_valid}, 32'h0);

    // 4: port filter, then checksum-field-zero bypass
    do_reset();
    cfg_port_en = 1'b1;
    build(16'd1234, 16'd5001, 10, 8'h11, 1'b0); send(pkt.size()); steps(8);
    check("t4_filt_valid", {31'h0, rec_valid}, 32'h0);
    check("t4_filt_drop", {16'h0, drop_cnt}, 32'd1);
    build(16'd1234, 16'd5000, 10, 8'h12, 1'b1); send(pkt.size());
    wait_valid(10);
    check("t4_zero_valid", {31'h0, rec_valid}, 32'h1);
    check("t4_zero_len", {16'h0, rec_length}, 32'd10);
    check("t4_err", {16'h0, err_cnt}, 32'd0);
    cfg_port_en = 1'b0;

    // 5: restart mid-payload
    do_reset();
    build(16'd7, 16'd8, 20, 8'h60, 1'b0); send(14);
    build(16'd9, 16'd10, 12, 8'h70, 1'b0); send(pkt.size());
    wait_valid(10);
    check("t5_valid", {31'h0, rec_valid}, 32'h1);
    check("t5_len", {16'h0, rec_length}, 32'd12);
    check("t5_drop", {16'h0, drop_cnt}, 32'd1);
    read_chk("t5_d0", 0, 8'h70);
    read_chk("t5_d11", 11, 8'hBD);
    release_buf();
    check("t5_only_b", {31'h0, rec_valid}, 32'h0);

    // 6: mac error in VERIFY1, then reset mid-DATA
    do_reset();
    build(16'd1234, 16'd5000, 10, 8'h80, 1'b0); send(pkt.size());
    mac_rec_error = 1'b1;
    step();
    mac_rec_error = 1'b0;
    steps(5);
    check("t6_mac_valid", {31'h0, rec_valid}, 32'h0);
    check("t6_mac_drop", {16'h0, drop_cnt}, 32'd1);
    check("t6_mac_err", {16'h0, err_cnt}, 32'd0);
    build(16'd1234, 16'd5000, 16, 8'h90, 1'b0); send(12);
    rstn = 1'b0;
    step();
    check("t6_rst_drop", {16'h0, drop_cnt}, 32'd0);
    check("t6_rst_valid", {31'h0, rec_valid}, 32'h0);
    rstn = 1'b1;
    steps(3);
    check("t6_after_valid", {31'h0, rec_valid}, 32'h0);
    build(16'd1234, 16'd5000, 2, 8'hA0, 1'b0); send(pkt.size());
    wait_valid(10);
    check("t6_new_len", {16'h0, rec_length}, 32'd2);

    // 7: length boundaries
    do_reset();
    build(16'd1234, 16'd5000, 0, 8'h00, 1'b0); send(pkt.size());
    wait_valid(10);
    check("t7_zero_valid", {31'h0, rec_valid}, 32'h1);
    check("t7_zero_len", {16'h0, rec_length}, 32'd0);
    release_buf();
    build(16'd1234, 16'd5000, 6, 8'hB0, 1'b0);
    upper_layer_data_length = 16'd16;
    send(pkt.size()); steps(6);
    check("t7_mismatch_err", {16'h0, err_cnt}, 32'd1);
    check("t7_mismatch_valid", {31'h0, rec_valid}, 32'h0);
    build(16'd1234, 16'd5000, 0, 8'h00, 1'b1);
    pkt[4] = 8'h08; pkt[5] = 8'h09;
    upper_layer_data_length = 16'd2057;
    send(8); steps(3);
    check("t7_oversize_err", {16'h0, err_cnt}, 32'd2);
    check("t7_oversize_drop", {16'h0, drop_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
